multicycle_core: RTL and testbench

// - Parametrised multi-cycle RV32 core. Successor to the single-cycle top level.
// - One FSM-sequenced datapath with an internal register file and a single shared instr/data memory port.
// - The memory port uses a req/ready handshake, so wait-state memories are supported.
// - Exposes one selectable architectural register as Result. Start is gated by trigger.

---
 rtl/multicycle_core_if.sv | 29 ++
 rtl/multicycle_core.sv | 202 ++++++++++++++++++++
 tb/tb_multicycle_core.sv | 368 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_core_if.sv
// Shared instruction/data memory port of multicycle_core.
// The core drives the request side (master); the memory drives the response (slave).
//   mem_req    request valid; held with stable addr/we/wdata until mem_ready
//   mem_we     1 = store, 0 = read/fetch
//   mem_addr   byte address (word accesses only)
//   mem_wdata  store data
//   mem_rdata  read data, valid when mem_ready=1
//   mem_ready  transfer completes on an edge where mem_req & mem_ready
interface multicycle_core_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32
);
  logic                  mem_req;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  mem_ready;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ready
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ready
  );
endinterface

// File: rtl/multicycle_core.sv
// Multi-cycle RV32 subset core (ADD SUB AND OR SLT ADDI LW SW BEQ BNE JAL LUI).
// One FSM-sequenced datapath, internal register file, one shared memory port.
//   CLK      rising-edge clock
//   rst      synchronous active-high reset
//   trigger  start request, sampled only while idle
//   mem      memory port (master side of multicycle_core_if)
//   Result   x[RESULT_REG], combinational from the register file
//   halted   high once an illegal instruction was decoded; sticky until rst
module multicycle_core #(
  parameter int unsigned            DATA_WIDTH = 32,
  parameter int unsigned            ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0]  RESET_PC   = '0,
  parameter int unsigned            RESULT_REG = 10
) (
  input  logic                  CLK,
  input  logic                  rst,
  input  logic                  trigger,
  multicycle_core_if.master     mem,
  output logic [DATA_WIDTH-1:0] Result,
  output logic                  halted
);

  localparam logic [4:0] ResultIdx = 5'(RESULT_REG);

  typedef enum logic [2:0] {
    StIdle, StFetch, StDecode, StExecute, StMem, StWb, StHalt
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [31:0]           ir_q, ir_d;
  logic [DATA_WIDTH-1:0] a_q, a_d, b_q, b_d, alu_q, alu_d, mdr_q, mdr_d;
  logic [DATA_WIDTH-1:0] rf_q [32];
  logic                  rf_we;

  // Instruction fields and immediates, all taken from the held IR.
  logic [6:0]  opcode, funct7;
  logic [2:0]  funct3;
  logic [4:0]  rd, rs1, rs2;
  logic [31:0] imm_i, imm_s, imm_b, imm_j, imm_u;

  assign opcode = ir_q[6:0];
  assign rd     = ir_q[11:7];
  assign funct3 = ir_q[14:12];
  assign rs1    = ir_q[19:15];
  assign rs2    = ir_q[24:20];
  assign funct7 = ir_q[31:25];
  assign imm_i  = {{20{ir_q[31]}}, ir_q[31:20]};
  assign imm_s  = {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
  assign imm_b  = {{19{ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
  assign imm_j  = {{11{ir_q[31]}}, ir_q[31], ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0};
  assign imm_u  = {ir_q[31:12], 12'b0};

  logic is_r, is_addi, is_lw, is_sw, is_br, is_jal, is_lui, legal, taken;

  always_comb begin
    is_r = 1'b0;
    if (opcode == 7'b0110011) begin
      is_r = (funct7 == 7'b0000000 && (funct3 == 3'b000 || funct3 == 3'b111 ||
                                       funct3 == 3'b110 || funct3 == 3'b010)) ||
             (funct7 == 7'b0100000 && funct3 == 3'b000);
    end
  end

  assign is_addi = (opcode == 7'b0010011) && (funct3 == 3'b000);
  assign is_lw   = (opcode == 7'b0000011) && (funct3 == 3'b010);
  assign is_sw   = (opcode == 7'b0100011) && (funct3 == 3'b010);
  assign is_br   = (opcode == 7'b1100011) && (funct3[2:1] == 2'b00);
  assign is_jal  = (opcode == 7'b1101111);
  assign is_lui  = (opcode == 7'b0110111);
  assign legal   = is_r | is_addi | is_lw | is_sw | is_br | is_jal | is_lui;
  // funct3[0] selects BNE over BEQ.
  assign taken   = funct3[0] ? (a_q != b_q) : (a_q == b_q);

  logic [DATA_WIDTH-1:0] alu_res;

  always_comb begin
    alu_res = '0;
    if (is_lui) begin
      alu_res = imm_u;
    end else if (is_addi || is_lw) begin
      alu_res = a_q + imm_i;
    end else if (is_sw) begin
      alu_res = a_q + imm_s;
    end else begin
      case ({funct7[5], funct3})
        4'b0_000: alu_res = a_q + b_q;
        4'b1_000: alu_res = a_q - b_q;
        4'b0_111: alu_res = a_q & b_q;
        4'b0_110: alu_res = a_q | b_q;
        4'b0_010: alu_res = {{(DATA_WIDTH-1){1'b0}}, $signed(a_q) < $signed(b_q)};
        default:  alu_res = '0;
      endcase
    end
  end

  logic [ADDR_WIDTH-1:0] pc_plus4;
  logic                  req, we;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wdata;

  assign pc_plus4 = pc_q + ADDR_WIDTH'(4);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    a_d     = a_q;
    b_d     = b_q;
    alu_d   = alu_q;
    mdr_d   = mdr_q;
    rf_we   = 1'b0;
    req     = 1'b0;
    we      = 1'b0;
    addr    = pc_q;
    wdata   = b_q;
    unique case (state_q)
      StIdle: begin
        if (trigger) state_d = StFetch;
      end
      StFetch: begin
        req = 1'b1;
        if (mem.mem_ready) begin
          ir_d    = mem.mem_rdata;
          state_d = StDecode;
        end
      end
      StDecode: begin
        // rf_q[0] is never written, so x0 reads as zero.
        a_d     = rf_q[rs1];
        b_d     = rf_q[rs2];
        state_d = legal ? StExecute : StHalt;
      end
      StExecute: begin
        if (is_br) begin
          pc_d    = taken ? pc_q + ADDR_WIDTH'($signed(imm_b)) : pc_plus4;
          state_d = StFetch;
        end else if (is_jal) begin
          alu_d   = DATA_WIDTH'(pc_plus4);
          pc_d    = pc_q + ADDR_WIDTH'($signed(imm_j));
          state_d = StWb;
        end else begin
          alu_d   = alu_res;
          state_d = (is_lw || is_sw) ? StMem : StWb;
        end
      end
      StMem: begin
        req  = 1'b1;
        we   = is_sw;
        addr = ADDR_WIDTH'(alu_q);
        if (mem.mem_ready) begin
          if (is_sw) begin
            pc_d    = pc_plus4;
            state_d = StFetch;
          end else begin
            mdr_d   = mem.mem_rdata;
            state_d = StWb;
          end
        end
      end
      StWb: begin
        rf_we   = (rd != 5'd0);
        // JAL already moved the PC in EXECUTE.
        pc_d    = is_jal ? pc_q : pc_plus4;
        state_d = StFetch;
      end
      StHalt: ;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (rst) begin
      state_q <= StIdle;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      alu_q   <= '0;
      mdr_q   <= '0;
      for (int i = 0; i < 32; i++) rf_q[i] <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      a_q     <= a_d;
      b_q     <= b_d;
      alu_q   <= alu_d;
      mdr_q   <= mdr_d;
      if (rf_we) rf_q[rd] <= is_lw ? mdr_q : alu_q;
    end
  end

  assign mem.mem_req   = req;
  assign mem.mem_we    = we;
  assign mem.mem_addr  = addr;
  assign mem.mem_wdata = wdata;

  assign Result = rf_q[ResultIdx];
  assign halted = (state_q == StHalt);

endmodule

// File: tb/tb_multicycle_core.sv
// Bench for multicycle_core: directed programs plus random programs, checked against an
// instruction-level reference model that predicts every memory transfer, fetch spacing,
// load-to-Result timing and the final x10.
module tb_multicycle_core;

  logic        CLK = 1'b0;
  logic        rst;
  logic        trigger;
  logic [31:0] Result;
  logic        halted;

  always #5 CLK = ~CLK;

  multicycle_core_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus ();

  multicycle_core #(
    .DATA_WIDTH(32),
    .ADDR_WIDTH(32),
    .RESET_PC  (32'h0),
    .RESULT_REG(10)
  ) dut (
    .CLK    (CLK),
    .rst    (rst),
    .trigger(trigger),
    .mem    (bus),
    .Result (Result),
    .halted (halted)
  );

  typedef struct {
    bit          fetch;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;     // store data, or loaded value for loads
    int          cpi_prev;  // cycles owed to the previous instruction (0 = first fetch)
    bit          ld10;      // load that targets x10
  } xfer_t;

  xfer_t       exp_q[$];
  logic [31:0] mem  [256];  // memory seen by the DUT
  logic [31:0] mm   [256];  // model's memory
  logic [31:0] prog [256];
  int          rmode;       // 0 zero-wait, 1 random waits, 2 data accesses wait 3 cycles
  int          cyc = 0;
  int unsigned total = 0;
  int unsigned bad   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %08h expected %08h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Instruction encoders.
  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [2:0] f3,
                                        input int rd, input int rs1, input int rs2);
    return {f7, 5'(rs2), 5'(rs1), f3, 5'(rd), 7'h33};
  endfunction

  function automatic logic [31:0] enc_i(input logic [6:0] op, input logic [2:0] f3,
                                        input int rd, input int rs1, input int imm);
    logic [11:0] v;
    v = 12'(imm);
    return {v, 5'(rs1), f3, 5'(rd), op};
  endfunction

  function automatic logic [31:0] enc_s(input int rs2, input int rs1, input int imm);
    logic [11:0] v;
    v = 12'(imm);
    return {v[11:5], 5'(rs2), 5'(rs1), 3'b010, v[4:0], 7'h23};
  endfunction

  function automatic logic [31:0] enc_b(input logic [2:0] f3, input int rs1, input int rs2,
                                        input int imm);
    logic [12:0] v;
    v = 13'(imm);
    return {v[12], v[10:5], 5'(rs2), 5'(rs1), f3, v[4:1], v[11], 7'h63};
  endfunction

  function automatic logic [31:0] enc_j(input int rd, input int imm);
    logic [20:0] v;
    v = 21'(imm);
    return {v[20], v[10:1], v[11], v[19:12], 5'(rd), 7'h6f};
  endfunction

  // Instruction-set reference: runs the program in mm from address 0 until an
  // illegal instruction, queueing the bus transfers the core must make.
  task automatic model_run(output logic [31:0] x10);
    logic [31:0] x [32];
    logic [31:0] pc, ins, a, b, r, nxt, ea, immi, imms, immb, immj;
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic [6:0]  f7;
    int          cpi, prev;
    bit          ok, wr;
    xfer_t       t;
    for (int i = 0; i < 32; i++) x[i] = '0;
    pc   = '0;
    prev = 0;
    for (int step = 0; step < 4000; step++) begin
      ins = mm[pc[9:2]];
      t.fetch = 1'b1; t.we = 1'b0; t.addr = pc; t.wdata = '0; t.cpi_prev = prev; t.ld10 = 1'b0;
      exp_q.push_back(t);
      rd   = ins[11:7];
      f3   = ins[14:12];
      f7   = ins[31:25];
      a    = x[ins[19:15]];
      b    = x[ins[24:20]];
      immi = {{20{ins[31]}}, ins[31:20]};
      imms = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      immb = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      immj = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      ok = 1'b1; wr = 1'b0; cpi = 4; nxt = pc + 4; r = '0;
      case (ins[6:0])
        7'h33: begin
          wr = 1'b1;
          if (f7 == 7'h00 && f3 == 3'd0)      r = a + b;
          else if (f7 == 7'h20 && f3 == 3'd0) r = a - b;
          else if (f7 == 7'h00 && f3 == 3'd7) r = a & b;
          else if (f7 == 7'h00 && f3 == 3'd6) r = a | b;
          else if (f7 == 7'h00 && f3 == 3'd2) r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
          else ok = 1'b0;
        end
        7'h13: begin wr = 1'b1; r = a + immi; ok = (f3 == 3'd0); end
        7'h37: begin wr = 1'b1; r = {ins[31:12], 12'b0}; end
        7'h03: begin
          ok = (f3 == 3'd2);
          if (ok) begin
            ea = a + immi; r = mm[ea[9:2]]; wr = 1'b1; cpi = 5;
            t.fetch = 1'b0; t.we = 1'b0; t.addr = ea; t.wdata = r; t.cpi_prev = 0;
            t.ld10 = (rd == 5'd10);
            exp_q.push_back(t);
          end
        end
        7'h23: begin
          ok = (f3 == 3'd2);
          if (ok) begin
            ea = a + imms; mm[ea[9:2]] = b;
            t.fetch = 1'b0; t.we = 1'b1; t.addr = ea; t.wdata = b; t.cpi_prev = 0; t.ld10 = 1'b0;
            exp_q.push_back(t);
          end
        end
        7'h63: begin
          ok  = (f3 == 3'd0 || f3 == 3'd1);
          cpi = 3;
          if ((f3 == 3'd0) ? (a == b) : (a != b)) nxt = pc + immb;
        end
        7'h6f: begin wr = 1'b1; r = pc + 4; nxt = pc + immj; end
        default: ok = 1'b0;
      endcase
      if (!ok) break;
      if (wr && rd != 5'd0) x[rd] = r;
      pc   = nxt;
      prev = cpi;
    end
    x10 = x[10];
  endtask

  // Memory responder and scoreboard; samples and drives on the falling edge.
  initial begin
    bit          waiting, rdy, have;
    logic        hold_we;
    logic [31:0] hold_addr, hold_wdata, ld_val;
    int          wait_run, waits_since, last_fetch, ld_chk_at;
    xfer_t       e;
    bus.mem_ready = 1'b0;
    bus.mem_rdata = '0;
    waiting = 1'b0; wait_run = 0; waits_since = 0; last_fetch = 0; ld_chk_at = -1;
    hold_we = 1'b0; hold_addr = '0; hold_wdata = '0; ld_val = '0;
    forever begin
      @(negedge CLK);
      cyc++;
      if (rst) begin
        bus.mem_ready = 1'b0;
        waiting = 1'b0; wait_run = 0; waits_since = 0; ld_chk_at = -1;
      end else begin
        if (ld_chk_at == cyc) check_eq("load_to_result", Result, ld_val);
        if (waiting) begin
          check_eq("wait_req_held", 32'(bus.mem_req), 32'd1);
          check_eq("wait_addr_held", bus.mem_addr, hold_addr);
          check_eq("wait_we_held", 32'(bus.mem_we), 32'(hold_we));
          if (hold_we) check_eq("wait_wdata_held", bus.mem_wdata, hold_wdata);
        end
        if (bus.mem_req) begin
          have = (exp_q.size() != 0);
          if (!have) check_eq("unexpected_xfer", 32'(bus.mem_req), 32'd0);
          else e = exp_q[0];
          case (rmode)
            0:       rdy = 1'b1;
            1:       rdy = ($urandom_range(0, 2) != 0);
            default: rdy = !have || e.fetch || wait_run >= 3;
          endcase
          if (rdy) begin
            bus.mem_ready = 1'b1;
            bus.mem_rdata = mem[bus.mem_addr[9:2]];
            if (have) begin
              e = exp_q.pop_front();
              check_eq("xfer_we", 32'(bus.mem_we), 32'(e.we));
              check_eq(e.fetch ? "fetch_addr" : "data_addr", bus.mem_addr, e.addr);
              if (e.we) check_eq("store_data", bus.mem_wdata, e.wdata);
              if (e.fetch && e.cpi_prev != 0)
                check_eq("fetch_spacing", 32'(cyc - last_fetch), 32'(e.cpi_prev + waits_since));
              if (e.fetch) begin
                last_fetch  = cyc;
                waits_since = 0;
              end
              if (e.ld10) begin
                ld_chk_at = cyc + 2;
                ld_val    = e.wdata;
              end
            end
            if (bus.mem_we) mem[bus.mem_addr[9:2]] = bus.mem_wdata;
            waiting  = 1'b0;
            wait_run = 0;
          end else begin
            bus.mem_ready = 1'b0;
            bus.mem_rdata = $urandom;
            waiting    = 1'b1;
            hold_we    = bus.mem_we;
            hold_addr  = bus.mem_addr;
            hold_wdata = bus.mem_wdata;
            wait_run++;
            waits_since++;
          end
        end else begin
          // Ready and data toggle freely while nothing is requested.
          bus.mem_ready = 1'($urandom_range(0, 1));
          bus.mem_rdata = $urandom;
          waiting = 1'b0;
        end
      end
    end
  end

  task automatic clear_prog();
    for (int i = 0; i < 256; i++) prog[i] = '0;
    for (int i = 128; i < 192; i++) prog[i] = $urandom;
  endtask

  task automatic run_prog(input int mode);
    logic [31:0] mx10;
    int          n;
    for (int i = 0; i < 256; i++) begin
      mem[i] = prog[i];
      mm[i]  = prog[i];
    end
    exp_q.delete();
    model_run(mx10);
    rmode = mode;
    rst = 1'b1;
    repeat (2) begin @(posedge CLK); #1; end
    check_eq("reset_halted", 32'(halted), 32'd0);
    check_eq("reset_result", Result, 32'd0);
    check_eq("reset_req", 32'(bus.mem_req), 32'd0);
    rst = 1'b0;
    trigger = 1'b1;
    @(posedge CLK); #1;
    trigger = 1'b0;
    n = 0;
    while (!halted && n < 4000) begin
      @(posedge CLK); #1;
      n++;
    end
    check_eq("halt_reached", 32'(halted), 32'd1);
    repeat (4) begin
      @(posedge CLK); #1;
      check_eq("halt_no_req", 32'(bus.mem_req), 32'd0);
    end
    check_eq("final_result", Result, mx10);
    check_eq("xfers_left", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic gen_random();
    int n, k, rd, rs1, rs2, lim;
    clear_prog();
    n = $urandom_range(20, 40);
    for (int i = 0; i < n; i++) begin
      k   = $urandom_range(0, 9);
      rd  = $urandom_range(0, 15);
      rs1 = $urandom_range(0, 15);
      rs2 = $urandom_range(0, 15);
      lim = (n - i < 3) ? n - i : 3;
      case (k)
        0, 1: begin
          case ($urandom_range(0, 4))
            0:       prog[i] = enc_r(7'h00, 3'd0, rd, rs1, rs2);
            1:       prog[i] = enc_r(7'h20, 3'd0, rd, rs1, rs2);
            2:       prog[i] = enc_r(7'h00, 3'd7, rd, rs1, rs2);
            3:       prog[i] = enc_r(7'h00, 3'd6, rd, rs1, rs2);
            default: prog[i] = enc_r(7'h00, 3'd2, rd, rs1, rs2);
          endcase
        end
        2, 3, 9: prog[i] = enc_i(7'h13, 3'd0, rd, rs1, int'($urandom_range(0, 4095)) - 2048);
        4: prog[i] = {20'($urandom), 5'(rd), 7'h37};
        5: prog[i] = enc_i(7'h03, 3'd2, rd, 0, 512 + 4 * int'($urandom_range(0, 63)));
        6: prog[i] = enc_s(rs2, 0, 512 + 4 * int'($urandom_range(0, 63)));
        7: begin
          if ($urandom_range(0, 1) == 1) rs2 = rs1;
          prog[i] = enc_b(3'($urandom_range(0, 1)), rs1, rs2, 4 * int'($urandom_range(1, lim)));
        end
        default: prog[i] = enc_j(rd, 4 * int'($urandom_range(1, lim)));
      endcase
    end
    prog[n] = 32'h0000_0000;
  endtask

  initial begin
    rst     = 1'b1;
    trigger = 1'b0;
    rmode   = 0;
    repeat (2) begin @(posedge CLK); #1; end
    rst = 1'b0;
    repeat (10) begin
      @(posedge CLK); #1;
      check_eq("idle_req", 32'(bus.mem_req), 32'd0);
      check_eq("idle_result", Result, 32'd0);
      check_eq("idle_halted", 32'(halted), 32'd0);
    end

    // addi x10,5; sw x10,8(x0) overwrites word 8, whose new value 5 is then illegal.
    clear_prog();
    prog[0] = 32'h0050_0513;
    prog[1] = 32'h00A0_2423;
    prog[2] = 32'h0080_2503;
    run_prog(0);

    // lw x10,8(x0) loads its own encoding, data access held off for 3 cycles.
    clear_prog();
    prog[0] = 32'h0000_0013;
    prog[1] = 32'h0000_0013;
    prog[2] = 32'h0080_2503;
    run_prog(2);

    // Count-down loop: fetches 0,4,8,4,8,4,8,12.
    clear_prog();
    prog[0] = 32'h0030_0513;
    prog[1] = 32'hFFF5_0513;
    prog[2] = 32'hFE05_1EE3;
    run_prog(0);

    // Writes to x0 are discarded.
    clear_prog();
    prog[0] = 32'h0090_0513;
    prog[1] = 32'h0070_0013;
    prog[2] = enc_r(7'h00, 3'd0, 10, 0, 0);
    run_prog(1);

    // LUI, JAL, SLT with negative operands, then halt.
    clear_prog();
    prog[0] = {20'hFFFFF, 5'd1, 7'h37};
    prog[1] = enc_r(7'h00, 3'd2, 10, 1, 0);
    prog[2] = enc_j(2, 8);
    prog[3] = enc_i(7'h13, 3'd0, 10, 0, 77);
    prog[4] = enc_r(7'h00, 3'd0, 10, 10, 2);
    run_prog(0);

    for (int t = 0; t < 6; t++) begin
      gen_random();
      run_prog(t % 3);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
